// File: rtl/sc_levelsequencer_if.sv
// Level sequencer signal bundle: game state and advance strobe in, level and flags out.
// Pure wiring, no storage and no latency of its own.
// No backpressure: the strobe is fire-and-forget and the outputs are level signals.
interface sc_levelsequencer_if #(
  parameter int LEVEL_WIDTH = 3
);
  logic [1:0]             SC_LEVELSEQ_CurrentState_InBus;
  logic                   SC_LEVELSEQ_CountSignal_InLow;
  logic [LEVEL_WIDTH-1:0] SC_LEVELSEQ_Data_OutBus;
  logic                   SC_LEVELSEQ_LevelUp_OutHigh;
  logic                   SC_LEVELSEQ_MaxLevel_OutHigh;
  logic                   SC_LEVELSEQ_Busy_OutHigh;

  // Game logic side: drives state and strobe, consumes level and flags.
  modport master (
    output SC_LEVELSEQ_CurrentState_InBus,
    output SC_LEVELSEQ_CountSignal_InLow,
    input  SC_LEVELSEQ_Data_OutBus,
    input  SC_LEVELSEQ_LevelUp_OutHigh,
    input  SC_LEVELSEQ_MaxLevel_OutHigh,
    input  SC_LEVELSEQ_Busy_OutHigh
  );

  // Sequencer side.
  modport slave (
    input  SC_LEVELSEQ_CurrentState_InBus,
    input  SC_LEVELSEQ_CountSignal_InLow,
    output SC_LEVELSEQ_Data_OutBus,
    output SC_LEVELSEQ_LevelUp_OutHigh,
    output SC_LEVELSEQ_MaxLevel_OutHigh,
    output SC_LEVELSEQ_Busy_OutHigh
  );
endinterface

// File: rtl/sc_levelsequencer.sv
// Level register for the game: follows game state, counts debounced falling edges of the advance strobe.
// Strobe-to-level latency is 3 clock edges (2-stage synchroniser + edge register); reset clears asynchronously.
// No backpressure: strobes arriving during hold-off, at saturation or outside START are dropped, never queued.
module sc_levelsequencer #(
  parameter int LEVEL_WIDTH    = 3,
  parameter int START_LEVEL    = 1,
  parameter int MAX_LEVEL      = 6,
  parameter int END_LEVEL      = 7,
  parameter int WRAP_MODE      = 0,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int HOLDOFF_WIDTH  = 8
) (
  input logic                 SC_LEVELSEQ_CLOCK_50,
  input logic                 SC_LEVELSEQ_RESET_InLow,
  sc_levelsequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    GAME_WAIT   = 2'd0,
    GAME_START  = 2'd1,
    GAME_END    = 2'd2,
    GAME_WAIT_1 = 2'd3
  } gameState_t;

  localparam logic [LEVEL_WIDTH-1:0]   START_LVL = LEVEL_WIDTH'(START_LEVEL);
  localparam logic [LEVEL_WIDTH-1:0]   MAX_LVL   = LEVEL_WIDTH'(MAX_LEVEL);
  localparam logic [LEVEL_WIDTH-1:0]   END_LVL   = LEVEL_WIDTH'(END_LEVEL);
  localparam logic [LEVEL_WIDTH-1:0]   LVL_ONE   = LEVEL_WIDTH'(1);
  localparam logic [HOLDOFF_WIDTH-1:0] HOLD_LOAD = HOLDOFF_WIDTH'(HOLDOFF_CYCLES);
  localparam logic [HOLDOFF_WIDTH-1:0] HOLD_ONE  = HOLDOFF_WIDTH'(1);

  gameState_t               gameState;
  logic                     syncS1;
  logic                     syncS2;
  logic                     edgeS3;
  logic                     strobeEvent;
  logic [LEVEL_WIDTH-1:0]   levelReg;
  logic                     levelUpReg;
  logic [HOLDOFF_WIDTH-1:0] holdCount;

  assign gameState   = gameState_t'(bus.SC_LEVELSEQ_CurrentState_InBus);
  // A falling edge of the (synchronised) active-low strobe: previous sample high, current low.
  assign strobeEvent = edgeS3 & ~syncS2;

  // Two-flop synchroniser plus edge register; all idle high so reset never fakes an edge.
  always_ff @(posedge SC_LEVELSEQ_CLOCK_50 or negedge SC_LEVELSEQ_RESET_InLow) begin
    if (!SC_LEVELSEQ_RESET_InLow) begin
      syncS1 <= 1'b1;
      syncS2 <= 1'b1;
      edgeS3 <= 1'b1;
    end else begin
      syncS1 <= bus.SC_LEVELSEQ_CountSignal_InLow;
      syncS2 <= syncS1;
      edgeS3 <= syncS2;
    end
  end

  // Level, level-up pulse and hold-off timer, driven by the current game state.
  always_ff @(posedge SC_LEVELSEQ_CLOCK_50 or negedge SC_LEVELSEQ_RESET_InLow) begin
    if (!SC_LEVELSEQ_RESET_InLow) begin
      levelReg   <= '0;
      levelUpReg <= 1'b0;
      holdCount  <= '0;
    end else begin
      levelUpReg <= 1'b0;
      unique case (gameState)
        GAME_WAIT: begin
          levelReg  <= '0;
          holdCount <= '0;
        end
        GAME_WAIT_1: begin
          levelReg  <= START_LVL;
          holdCount <= '0;
        end
        GAME_END: begin
          levelReg  <= END_LVL;
          holdCount <= '0;
        end
        GAME_START: begin
          if (strobeEvent && (holdCount == '0)) begin
            // A level above MAX (e.g. arriving from END) behaves exactly like sitting at MAX.
            if (levelReg < MAX_LVL) begin
              levelReg   <= levelReg + LVL_ONE;
              levelUpReg <= 1'b1;
              holdCount  <= HOLD_LOAD;
            end else if (WRAP_MODE != 0) begin
              levelReg   <= START_LVL;
              levelUpReg <= 1'b1;
              holdCount  <= HOLD_LOAD;
            end
          end else if (holdCount != '0) begin
            holdCount <= holdCount - HOLD_ONE;
          end
        end
        default: begin
          levelReg  <= '0;
          holdCount <= '0;
        end
      endcase
    end
  end

  assign bus.SC_LEVELSEQ_Data_OutBus      = levelReg;
  assign bus.SC_LEVELSEQ_LevelUp_OutHigh  = levelUpReg;
  assign bus.SC_LEVELSEQ_MaxLevel_OutHigh = (levelReg >= MAX_LVL);
  assign bus.SC_LEVELSEQ_Busy_OutHigh     = (holdCount != '0);

endmodule

// File: tb/tb_sc_levelsequencer.sv
// Self-checking bench for sc_levelsequencer: saturating and wrapping instances driven in parallel.
// Inputs change 2 time units after the rising edge; outputs are checked there or on the falling edge.
// Every counted advance pushes its expected level; the LevelUp monitor pops and compares it.
module tb_sc_levelsequencer;

  logic       clk;
  logic       rstN;
  logic [1:0] gameState;
  logic       countN;

  int checkCount;
  int errorCount;
  int levelUpSeen;
  logic [2:0] expQ[$];

  sc_levelsequencer_if #(.LEVEL_WIDTH(3)) mainBus ();
  sc_levelsequencer_if #(.LEVEL_WIDTH(3)) wrapBus ();

  assign mainBus.SC_LEVELSEQ_CurrentState_InBus = gameState;
  assign mainBus.SC_LEVELSEQ_CountSignal_InLow  = countN;
  assign wrapBus.SC_LEVELSEQ_CurrentState_InBus = gameState;
  assign wrapBus.SC_LEVELSEQ_CountSignal_InLow  = countN;

  sc_levelsequencer #(.WRAP_MODE(0)) dutSat (
    .SC_LEVELSEQ_CLOCK_50    (clk),
    .SC_LEVELSEQ_RESET_InLow (rstN),
    .bus                     (mainBus)
  );

  sc_levelsequencer #(.WRAP_MODE(1)) dutWrap (
    .SC_LEVELSEQ_CLOCK_50    (clk),
    .SC_LEVELSEQ_RESET_InLow (rstN),
    .bus                     (wrapBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Scoreboard consumer: each LevelUp pulse of the saturating instance must match a queued level.
  always @(negedge clk) begin
    if (mainBus.SC_LEVELSEQ_LevelUp_OutHigh === 1'b1) begin
      levelUpSeen++;
      if (expQ.size() == 0) checkValue("unexpected_levelup", 32'd1, 32'd0);
      else checkValue("levelup_data", 32'(mainBus.SC_LEVELSEQ_Data_OutBus), 32'(expQ.pop_front()));
    end
  end

  // One single-cycle strobe that must count: checks 3-edge latency, pulse and 4-cycle busy window.
  task automatic countedStrobe(input logic [2:0] oldLevel, input logic [2:0] newLevel);
    expQ.push_back(newLevel);
    countN = 1'b0;
    tick(1);
    countN = 1'b1;
    tick(1);
    checkValue("e2_data_unchanged", 32'(mainBus.SC_LEVELSEQ_Data_OutBus), 32'(oldLevel));
    tick(1);
    checkValue("e3_data", 32'(mainBus.SC_LEVELSEQ_Data_OutBus), 32'(newLevel));
    checkValue("e3_levelup", 32'(mainBus.SC_LEVELSEQ_LevelUp_OutHigh), 32'd1);
    checkValue("e3_busy", 32'(mainBus.SC_LEVELSEQ_Busy_OutHigh), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkValue("busy_window", 32'(mainBus.SC_LEVELSEQ_Busy_OutHigh), 32'd1);
      checkValue("levelup_one_cycle", 32'(mainBus.SC_LEVELSEQ_LevelUp_OutHigh), 32'd0);
    end
    tick(1);
    checkValue("busy_released", 32'(mainBus.SC_LEVELSEQ_Busy_OutHigh), 32'd0);
    tick(3);
  endtask

  initial begin
    int luBefore;
    checkCount  = 0;
    errorCount  = 0;
    levelUpSeen = 0;
    rstN      = 1'b0;
    gameState = 2'd0;
    countN    = 1'b1;

    // 1. Reset values before any clock edge, then WAIT ignores strobes.
    #3;
    checkValue("reset_data", 32'(mainBus.SC_LEVELSEQ_Data_OutBus), 32'd0);
    checkValue("reset_levelup", 32'(mainBus.SC_LEVELSEQ_LevelUp_OutHigh), 32'd0);
    checkValue("reset_busy", 32'(mainBus.SC_LEVELSEQ_Busy_OutHigh), 32'd0);
    tick(2);
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      countN = 1'b0;
      tick(1);
      countN = 1'b1;
      tick(3);
    end
    checkValue("wait_data", 32'(mainBus.SC_LEVELSEQ_Data_OutBus), 32'd0);
    checkValue("wait_busy", 32'(mainBus.SC_LEVELSEQ_Busy_OutHigh), 32'd0);
    checkValue("wait_no_levelup", 32'(levelUpSeen), 32'd0);

    // 2. WAIT_1 loads the start level, then three counted advances in START.
    gameState = 2'd3;
    tick(2);
    checkValue("wait1_data", 32'(mainBus.SC_LEVELSEQ_Data_OutBus), 32'd1);
    checkValue("wait1_maxlevel", 32'(mainBus.SC_LEVELSEQ_MaxLevel_OutHigh), 32'd0);
    gameState = 2'd1;
    tick(1);
    countedStrobe(3'd1, 3'd2);
    countedStrobe(3'd2, 3'd3);
    countedStrobe(3'd3, 3'd4);

    // 3. Second falling edge inside the hold-off window is dropped.
    gameState = 2'd3;
    tick(2);
    gameState = 2'd1;
    tick(1);
    countedStrobe(3'd1, 3'd2);
    luBefore = levelUpSeen;
    expQ.push_back(3'd3);
    countN = 1'b0;
    tick(1);
    countN = 1'b1;
    tick(1);
    countN = 1'b0;
    tick(1);
    checkValue("holdoff_first_counts", 32'(mainBus.SC_LEVELSEQ_Data_OutBus), 32'd3);
    countN = 1'b1;
    tick(8);
    checkValue("holdoff_second_dropped", 32'(mainBus.SC_LEVELSEQ_Data_OutBus), 32'd3);
    checkValue("holdoff_one_pulse", 32'(levelUpSeen - luBefore), 32'd1);
    countedStrobe(3'd3, 3'd4);

    // 4. At MAX: saturating instance holds, wrapping instance returns to START_LEVEL.
    countedStrobe(3'd4, 3'd5);
    countedStrobe(3'd5, 3'd6);
    checkValue("at_max_flag", 32'(mainBus.SC_LEVELSEQ_MaxLevel_OutHigh), 32'd1);
    checkValue("wrap_at_max_data", 32'(wrapBus.SC_LEVELSEQ_Data_OutBus), 32'd6);
    countN = 1'b0;
    tick(1);
    countN = 1'b1;
    tick(2);
    checkValue("sat_data", 32'(mainBus.SC_LEVELSEQ_Data_OutBus), 32'd6);
    checkValue("sat_levelup", 32'(mainBus.SC_LEVELSEQ_LevelUp_OutHigh), 32'd0);
    checkValue("sat_busy", 32'(mainBus.SC_LEVELSEQ_Busy_OutHigh), 32'd0);
    checkValue("sat_maxlevel", 32'(mainBus.SC_LEVELSEQ_MaxLevel_OutHigh), 32'd1);
    checkValue("wrap_data", 32'(wrapBus.SC_LEVELSEQ_Data_OutBus), 32'd1);
    checkValue("wrap_levelup", 32'(wrapBus.SC_LEVELSEQ_LevelUp_OutHigh), 32'd1);
    checkValue("wrap_maxlevel", 32'(wrapBus.SC_LEVELSEQ_MaxLevel_OutHigh), 32'd0);
    checkValue("wrap_busy", 32'(wrapBus.SC_LEVELSEQ_Busy_OutHigh), 32'd1);
    tick(4);
    checkValue("sat_busy_later", 32'(mainBus.SC_LEVELSEQ_Busy_OutHigh), 32'd0);
    checkValue("sat_data_later", 32'(mainBus.SC_LEVELSEQ_Data_OutBus), 32'd6);

    // 5. Long strobe counts once; strobe low across reset release counts once.
    gameState = 2'd3;
    tick(2);
    gameState = 2'd1;
    tick(1);
    countedStrobe(3'd1, 3'd2);
    luBefore = levelUpSeen;
    expQ.push_back(3'd3);
    countN = 1'b0;
    tick(20);
    countN = 1'b1;
    tick(5);
    checkValue("long_strobe_data", 32'(mainBus.SC_LEVELSEQ_Data_OutBus), 32'd3);
    checkValue("long_strobe_one_pulse", 32'(levelUpSeen - luBefore), 32'd1);
    rstN   = 1'b0;
    countN = 1'b0;
    #1;
    checkValue("async_reset_data", 32'(mainBus.SC_LEVELSEQ_Data_OutBus), 32'd0);
    tick(2);
    expQ.push_back(3'd1);
    rstN = 1'b1;
    tick(2);
    checkValue("release_e2_data", 32'(mainBus.SC_LEVELSEQ_Data_OutBus), 32'd0);
    tick(1);
    checkValue("release_e3_data", 32'(mainBus.SC_LEVELSEQ_Data_OutBus), 32'd1);
    checkValue("release_e3_levelup", 32'(mainBus.SC_LEVELSEQ_LevelUp_OutHigh), 32'd1);
    tick(6);
    countN = 1'b1;
    tick(3);
    checkValue("release_no_second", 32'(mainBus.SC_LEVELSEQ_Data_OutBus), 32'd1);

    // 6. END forces the end level; reset mid-pulse clears outputs without a clock.
    gameState = 2'd2;
    tick(1);
    checkValue("end_data", 32'(mainBus.SC_LEVELSEQ_Data_OutBus), 32'd7);
    checkValue("end_maxlevel", 32'(mainBus.SC_LEVELSEQ_MaxLevel_OutHigh), 32'd1);
    checkValue("end_busy", 32'(mainBus.SC_LEVELSEQ_Busy_OutHigh), 32'd0);
    gameState = 2'd3;
    tick(2);
    gameState = 2'd1;
    tick(1);
    countN = 1'b0;
    tick(1);
    countN = 1'b1;
    tick(2);
    checkValue("pre_reset_levelup", 32'(mainBus.SC_LEVELSEQ_LevelUp_OutHigh), 32'd1);
    rstN = 1'b0;
    #1;
    checkValue("midpulse_reset_data", 32'(mainBus.SC_LEVELSEQ_Data_OutBus), 32'd0);
    checkValue("midpulse_reset_levelup", 32'(mainBus.SC_LEVELSEQ_LevelUp_OutHigh), 32'd0);
    checkValue("midpulse_reset_busy", 32'(mainBus.SC_LEVELSEQ_Busy_OutHigh), 32'd0);
    tick(2);

    checkValue("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
